// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-path blocks.
package uart_pkg;

  // Default port widths for the receive-idle timeout detector.
  localparam int UART_CNT_W = 16;
  localparam int UART_BT_W  = 8;

  // Smallest usable clocks-per-bit divisor; smaller programmed values are raised to this.
  localparam int MIN_BAUD = 2;

  // Receive-idle timeout FSM states.
  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FIRE,
    WAIT
  } rx_to_state_e;

endpackage

// File: rtl/uart_bit_tick.sv
// Bit-period divider for the RX idle timeout: clamps the programmed divisor
// and produces one tick per bit period while not held in clear.
module uart_bit_tick
  import uart_pkg::*;
#(
  parameter int CNT_W = UART_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] baud_raw,
  input  logic [CNT_W-1:0] baud_lat,
  output logic [CNT_W-1:0] baud_clamped,
  output logic             tick
);

  logic [CNT_W-1:0] clk_cnt;

  // Divisors 0 and 1 cannot form a bit period, so they run as MIN_BAUD.
  assign baud_clamped = (baud_raw < CNT_W'(MIN_BAUD)) ? CNT_W'(MIN_BAUD) : baud_raw;

  // baud_lat is always >= MIN_BAUD, so a held-cleared counter never ticks.
  assign tick = (clk_cnt == baud_lat - CNT_W'(1));

  // Clock counter: counts 0..baud_lat-1 and wraps on tick; clear dominates.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst || clr) begin
      clk_cnt <= '0;
    end else if (tick) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_timeout.sv
// Receive-idle (character) timeout detector. After each received byte it
// measures idle time in whole bit periods and pulses timeout_o once when the
// programmed number of bit-times passes with data still in the RX FIFO.
// Optional feature macro: UART_RX_TIMEOUT_STICKY_EN adds clr_i and a sticky
// timeout_sts_o status bit.
module uart_rx_timeout
  import uart_pkg::*;
#(
  parameter int CNT_W = UART_CNT_W,
  parameter int BT_W  = UART_BT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] baud_i,
  input  logic [BT_W-1:0]  thresh_i,
  input  logic             rx_done_i,
  input  logic             rx_start_i,
  input  logic             fifo_empty_i,
`ifdef UART_RX_TIMEOUT_STICKY_EN
  input  logic             clr_i,
  output logic             timeout_sts_o,
`endif
  output logic             timeout_o
);

  rx_to_state_e     state;
  logic [CNT_W-1:0] baud_q;
  logic [CNT_W-1:0] baud_clamped;
  logic [BT_W-1:0]  thresh_q;
  logic [BT_W-1:0]  bit_cnt;
  logic             tick;
  logic             start_ok;
  logic             terminal;
  logic             counting;

  // A byte arrival (re)starts a measurement only when enabled and a threshold is set;
  // with thresh_i = 0 the byte sends the detector to IDLE instead.
  assign start_ok = en_i && rx_done_i && (thresh_i != '0);

  // Last cycle of the last bit period of the idle window.
  assign terminal = tick && (bit_cnt == thresh_q - BT_W'(1));

  // True only when COUNT continues into COUNT without a restart; otherwise
  // both counters are held at zero, so every entry into COUNT starts clean.
  assign counting = (state == COUNT) && en_i && !rx_done_i && !rx_start_i &&
                    !fifo_empty_i && !terminal;

  uart_bit_tick #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk          (clk_i),
    .rst          (rst_i),
    .clr          (!counting),
    .baud_raw     (baud_i),
    .baud_lat     (baud_q),
    .baud_clamped (baud_clamped),
    .tick         (tick)
  );

  // Bit-time counter: advances once per bit period while counting.
  always_ff @(posedge clk_i) begin
    if (rst_i || !counting) begin
      bit_cnt <= '0;
    end else if (tick) begin
      bit_cnt <= bit_cnt + BT_W'(1);
    end
  end

  // Timeout FSM with registered pulse output and parameter latching on byte arrival.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      timeout_o <= 1'b0;
      baud_q    <= CNT_W'(MIN_BAUD);
      thresh_q  <= '0;
    end else begin
      timeout_o <= 1'b0;
      // Every start_ok leads into COUNT, so the parameters are captured here once.
      if (start_ok) begin
        baud_q   <= baud_clamped;
        thresh_q <= thresh_i;
      end
      case (state)
        IDLE: begin
          if (start_ok) state <= COUNT;
        end
        COUNT: begin
          if (!en_i) begin
            state <= IDLE;
          end else if (rx_done_i) begin
            state <= start_ok ? COUNT : IDLE;
          end else if (rx_start_i || fifo_empty_i) begin
            state <= IDLE;
          end else if (terminal) begin
            state     <= FIRE;
            timeout_o <= 1'b1;
          end
        end
        FIRE: begin
          if (start_ok) begin
            state <= COUNT;
          end else if (!en_i || rx_done_i) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!en_i) begin
            state <= IDLE;
          end else if (rx_done_i) begin
            state <= start_ok ? COUNT : IDLE;
          end else if (fifo_empty_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_TIMEOUT_STICKY_EN
  // Sticky status: set by the FIRE-cycle pulse, which outranks a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_sts_o <= 1'b0;
    end else if (timeout_o) begin
      timeout_sts_o <= 1'b1;
    end else if (clr_i) begin
      timeout_sts_o <= 1'b0;
    end
  end
`endif

endmodule
